// File: rtl/ex_trap_arb.sv
// External interrupt arbiter feeding the core trap request; optional EX_TRAP_EDGE_EN selects edge-triggered pending.
// Latency: source sampled at edge N+1 into pending, request valid after edge N+2; valid/claim are registered.
// Backpressure: valid holds in REQ until ex_trap_ready_i; no new request while a channel is in service.
module ex_trap_arb #(
    parameter int CH_NUM = 8,
    parameter int PRIO_W = 3,
    localparam int ID_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM-1:0]        irq_src_i,
    input  logic [CH_NUM-1:0]        irq_en_i,
    input  logic [CH_NUM*PRIO_W-1:0] irq_prio_i,
    output logic                     ex_trap_valid_o,
    input  logic                     ex_trap_ready_i,
    output logic [ID_W-1:0]          claim_id_o,
    input  logic                     complete_i,
    input  logic [ID_W-1:0]          complete_id_i,
    output logic [CH_NUM-1:0]        pending_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t              state;
    logic [CH_NUM-1:0]   pending;
    logic                valid_q;
    logic                busy_q;
    logic [ID_W-1:0]     claim_q;

    logic [PRIO_W-1:0]   prio [CH_NUM];
    logic [CH_NUM-1:0]   cand;
    logic [CH_NUM-1:0]   set_vec;
    logic [CH_NUM-1:0]   clr_vec;
    logic                any_cand;
    logic [ID_W-1:0]     win_id;
    logic [PRIO_W-1:0]   win_prio;
    logic                hs;

`ifdef EX_TRAP_EDGE_EN
    logic [CH_NUM-1:0]   src_q;
`endif

    assign hs = valid_q & ex_trap_ready_i;

    always_comb begin
        any_cand = 1'b0;
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            prio[i] = irq_prio_i[i*PRIO_W +: PRIO_W];
            cand[i] = pending[i] & irq_en_i[i] & (prio[i] != '0);
        end
        // Strict compare keeps the lowest index on ties.
        for (int i = 0; i < CH_NUM; i++) begin
            if (cand[i] && (prio[i] > win_prio)) begin
                any_cand = 1'b1;
                win_id   = ID_W'(i);
                win_prio = prio[i];
            end
        end
    end

    always_comb begin
`ifdef EX_TRAP_EDGE_EN
        // Edges during service of the same channel are kept and re-requested later.
        set_vec = irq_src_i & ~src_q;
`else
        set_vec = irq_src_i;
        if (state == ST_SERV) begin
            set_vec[claim_q] = 1'b0;
        end
`endif
        clr_vec = '0;
        if (hs) begin
            clr_vec[claim_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pending <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            claim_q <= '0;
`ifdef EX_TRAP_EDGE_EN
            src_q   <= '0;
`endif
        end else begin
            // Clear beats a same-cycle set on the claimed bit.
            pending <= (pending | set_vec) & ~clr_vec;
`ifdef EX_TRAP_EDGE_EN
            src_q   <= irq_src_i;
`endif
            case (state)
                ST_IDLE: begin
                    if (any_cand) begin
                        state   <= ST_REQ;
                        claim_q <= win_id;
                        valid_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (hs) begin
                        state   <= ST_SERV;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (!cand[claim_q]) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                    end else if (win_prio > prio[claim_q]) begin
                        claim_q <= win_id;
                    end
                end
                ST_SERV: begin
                    if (complete_i && (complete_id_i == claim_q)) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ex_trap_valid_o = valid_q;
    assign claim_id_o      = claim_q;
    assign pending_o       = pending;
    assign busy_o          = busy_q;

endmodule

// File: doc/ex_trap_arb.md
EX_TRAP_ARB -- requirements
Module: ex_trap_arb

Interface
REQ-001 SHALL have parameter CH_NUM, default 8 (legal 2..32): number of external interrupt channels.
REQ-002 SHALL have parameter PRIO_W, default 3 (legal 1..8): per-channel priority width; priority 0 = channel never requested.
REQ-003 SHALL have derived localparam ID_W = clog2(CH_NUM), minimum 1.
REQ-004 SHALL have one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 irq_src_i  input  CH_NUM  raw interrupt sources, bit i = channel i, synchronous to clk.
REQ-008 irq_en_i  input  CH_NUM  per-channel enable.
REQ-009 irq_prio_i  input  CH_NUM*PRIO_W  packed priorities, channel i at bits [i*PRIO_W +: PRIO_W].
REQ-010 ex_trap_valid_o  output  1  interrupt request to core (drives core_ex_trap_valid).
REQ-011 ex_trap_ready_i  input  1  core accepted request (from core_ex_trap_ready).
REQ-012 claim_id_o  output  ID_W  channel ID of current request/in-service channel.
REQ-013 complete_i  input  1  single-cycle handler-done pulse.
REQ-014 complete_id_i  input  ID_W  channel being completed.
REQ-015 pending_o  output  CH_NUM  pending register.
REQ-016 busy_o  output  1  high in SERV state.

Function
REQ-017 SHALL hold registered pending[CH_NUM]; candidate[i] = pending[i] & irq_en_i[i] & (prio[i] != 0).
REQ-018 Winner SHALL be candidate with highest priority; ties go to lowest index.
REQ-019 FSM states: IDLE, REQ, SERV.
REQ-020 IDLE: any candidate -> REQ next cycle, latch winner into claim_id_o; else stay.
REQ-021 REQ: ex_trap_valid_o = 1; on ex_trap_valid_o & ex_trap_ready_i -> SERV, clear pending[claim_id_o] same edge.
REQ-022 REQ, no handshake: if latched channel no longer a candidate, drop valid and -> IDLE; if a strictly higher-priority candidate exists, update claim_id_o, stay REQ with valid held high.
REQ-023 SERV: channel claim_id_o in service; pending for it SHALL NOT set until completion; other channels keep accumulating pending.
REQ-024 SERV: complete_i with complete_id_i == claim_id_o -> IDLE; mismatched complete_i ignored; complete_i outside SERV ignored.
REQ-025 No nesting: no new request while in SERV.
REQ-026 Latency: source asserted edge N -> pending set edge N+1 -> ex_trap_valid_o high after edge N+2 (state REQ).
REQ-027 After completion, a still-asserted source re-pends next edge; back-to-back handled with minimum 2 idle cycles between valid pulses.
REQ-028 Same-cycle set and clear of one pending bit: clear wins.
REQ-029 ex_trap_valid_o and claim_id_o SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-030 rst high at an edge: state IDLE, pending_o = 0, ex_trap_valid_o = 0, claim_id_o = 0, busy_o = 0, edge-detect history = 0.
REQ-031 rst mid-REQ or mid-SERV SHALL abandon the transaction; no completion required afterward.

Configuration
REQ-032 Macro EX_TRAP_EDGE_EN defined: pending[i] sets on 0->1 transition of irq_src_i[i] (one history flop per channel, adds no latency beyond REQ-026); edge during SERV of same channel is latched and re-requested after completion.
REQ-033 Macro EX_TRAP_EDGE_EN undefined: level mode; pending[i] follows irq_src_i[i] high (set-only, cleared by claim), edge during SERV dropped per REQ-023; no history flops.

Verification
REQ-034 Level mode, CH_NUM=8: src[3]=1, prio3=2, en=FF, ready tied 1 -> valid high 2 cycles after src, claim_id_o=3, busy_o next cycle, pending_o[3]=0.
REQ-035 src[2] prio 5 and src[6] prio 5 same cycle -> claim 2 first; after complete_id_i=2 -> claim 6.
REQ-036 In REQ with id=1 prio 1, ready=0, assert src[4] prio 7 -> claim_id_o changes to 4, valid stays high; then clear en[4] -> id reverts or valid drops as per REQ-022.
REQ-037 SERV id=5: complete_i with id=2 -> stays SERV; id=5 -> IDLE; src[5] still high -> new valid 2 cycles later.
REQ-038 EX_TRAP_EDGE_EN: src[0] pulse during SERV of channel 0 -> re-request after completion; rst asserted in REQ -> all outputs 0 next edge.
